// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port (if_*), the load/store port (ls_*) and the
//   single-port memory port (mem_*) that the arbiter sits between.
//
//   Handshake: a requester raises <port>_req with its fields stable and
//   keeps them stable until <port>_gnt pulses for one cycle; the grant is
//   the acceptance. A request may be withdrawn before the grant. Exactly one
//   <port>_rvalid pulse follows each grant after the memory latency, and
//   <port>_rdata is zero whenever <port>_rvalid is low.
//
//   Modports:
//     slave  - the arbiter: takes requests and mem_rdata, drives grants,
//              responses and the mem_* strobes.
//     master - the core/memory side: the mirror image.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [3:0]        ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the fetch port (read
//   only) and the load/store port. One access in flight at a time, fixed
//   read latency LATENCY, round-robin between the two ports on conflict.
//
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous, active-high reset
//     bus       mem_port_arbiter_if.slave (fetch, load/store and memory sides)
//     dbg_state 1 while the FSM is BUSY (access in flight)
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus,
  output logic dbg_state
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_t;
  typedef enum logic { PORT_IF = 1'b0, PORT_LS = 1'b1 } port_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  port_t            owner, owner_n;
  logic             owner_we, owner_we_n;   // in-flight LS access is a store
  port_t            last_winner, last_n;

  logic grant_if, grant_ls, resp, can_grant, pick_ls;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= PORT_IF;
      owner_we    <= 1'b0;
      last_winner <= PORT_IF;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      owner       <= owner_n;
      owner_we    <= owner_we_n;
      last_winner <= last_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    owner_n    = owner;
    owner_we_n = owner_we;
    last_n     = last_winner;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;

    // Outputs are forced quiet while rst is high, even mid-access, so an
    // in-flight response is dropped rather than delivered.
    resp      = !rst && (state == BUSY) && (cnt == CNT_W'(1));
    can_grant = !rst && ((state == IDLE) || resp);
    // LS wins when alone, or when both ask and IF won last time.
    pick_ls   = bus.ls_req && (!bus.if_req || (last_winner == PORT_IF));

    if (can_grant) begin
      if (pick_ls)         grant_ls = 1'b1;
      else if (bus.if_req) grant_if = 1'b1;
    end

    if (grant_if || grant_ls) begin
      state_n    = BUSY;
      cnt_n      = CNT_W'(LATENCY);
      owner_n    = grant_ls ? PORT_LS : PORT_IF;
      owner_we_n = grant_ls && bus.ls_we;
      last_n     = grant_ls ? PORT_LS : PORT_IF;
    end else if (resp) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == BUSY) begin
      cnt_n = cnt - CNT_W'(1);
    end

    bus.if_gnt    = grant_if;
    bus.ls_gnt    = grant_ls;
    bus.if_rvalid = resp && (owner == PORT_IF);
    bus.ls_rvalid = resp && (owner == PORT_LS);
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.ls_rdata  = (bus.ls_rvalid && !owner_we) ? bus.mem_rdata : '0;

    // Memory strobes carry the winner's fields only in a grant cycle.
    bus.mem_en    = grant_if || grant_ls;
    bus.mem_we    = grant_ls && bus.ls_we;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant_if) begin
      bus.mem_be   = 4'b1111;
      bus.mem_addr = bus.if_addr;
    end else if (grant_ls) begin
      bus.mem_be    = bus.ls_we ? bus.ls_be : 4'b1111;
      bus.mem_addr  = bus.ls_addr;
      bus.mem_wdata = bus.ls_we ? bus.ls_wdata : '0;
    end
  end

  assign dbg_state = (state == BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives two arbiters (LATENCY=1 and LATENCY=3), each in front of a small
//   byte-enabled synchronous memory model with a read pipeline of matching
//   depth. Expected read data is queued when a request is driven and popped
//   when the matching rvalid appears.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst1, rst3, tb_init;
  logic dbg1, dbg3;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst1), .bus(b1.slave), .dbg_state(dbg1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst3), .bus(b3.slave), .dbg_state(dbg3));

  // Memory models: read every cycle into a pipeline, write on mem_en&mem_we.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p1;
  logic [31:0] p3_0, p3_1, p3_2;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 32'h0;
        mem3[i] <= 32'h0;
      end
      mem1[1] <= 32'h00A00093;
      mem1[3] <= 32'h11223344;
      mem3[4] <= 32'h12345678;
      mem3[5] <= 32'hCAFEF00D;
    end else begin
      if (b1.mem_en && b1.mem_we)
        for (int i = 0; i < 4; i++)
          if (b1.mem_be[i]) mem1[b1.mem_addr[9:2]][8*i +: 8] <= b1.mem_wdata[8*i +: 8];
      if (b3.mem_en && b3.mem_we)
        for (int i = 0; i < 4; i++)
          if (b3.mem_be[i]) mem3[b3.mem_addr[9:2]][8*i +: 8] <= b3.mem_wdata[8*i +: 8];
    end
    p1   <= mem1[b1.mem_addr[9:2]];
    p3_0 <= mem3[b3.mem_addr[9:2]];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end

  assign b1.mem_rdata = p1;
  assign b3.mem_rdata = p3_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    check({tag, "_queued"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic drive1(input logic ir, input logic [31:0] ia, input logic lr,
                        input logic lw, input logic [3:0] lb,
                        input logic [31:0] la, input logic [31:0] ld);
    b1.if_req = ir; b1.if_addr = ia; b1.ls_req = lr; b1.ls_we = lw;
    b1.ls_be = lb; b1.ls_addr = la; b1.ls_wdata = ld;
  endtask

  task automatic drive3(input logic ir, input logic [31:0] ia, input logic lr,
                        input logic lw, input logic [3:0] lb,
                        input logic [31:0] la, input logic [31:0] ld);
    b3.if_req = ir; b3.if_addr = ia; b3.ls_req = lr; b3.ls_we = lw;
    b3.ls_be = lb; b3.ls_addr = la; b3.ls_wdata = ld;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] flags1();
    return {27'd0, b1.if_gnt, b1.ls_gnt, b1.if_rvalid, b1.ls_rvalid, b1.mem_en};
  endfunction

  function automatic logic [31:0] flags3();
    return {27'd0, b3.if_gnt, b3.ls_gnt, b3.if_rvalid, b3.ls_rvalid, b3.mem_en};
  endfunction

  initial begin
    // Reset held with both ports requesting.
    rst1 = 1'b1; rst3 = 1'b1; tb_init = 1'b1;
    drive1(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    drive3(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("rst_flags1", flags1(), 32'h0);
      check("rst_flags3", flags3(), 32'h0);
    end
    tick();
    rst1 = 1'b0; rst3 = 1'b0; tb_init = 1'b0;
    drive1(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive3(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("post_rst_flags1", flags1(), 32'h0);
    check("post_rst_addr1", b1.mem_addr, 32'h0);
    check("post_rst_dbg1", 32'(dbg1), 32'h0);

    // Single fetch at LATENCY=1.
    tick(); drive1(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    exp_q.push_back(32'h00A00093);
    #1;
    check("t2_if_gnt", 32'(b1.if_gnt), 32'h1);
    check("t2_mem_en", 32'(b1.mem_en), 32'h1);
    check("t2_mem_addr", b1.mem_addr, 32'h4);
    check("t2_mem_we", 32'(b1.mem_we), 32'h0);
    check("t2_mem_be", 32'(b1.mem_be), 32'hF);
    check("t2_mem_wdata", b1.mem_wdata, 32'h0);
    tick(); drive1(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("t2_if_rvalid", 32'(b1.if_rvalid), 32'h1);
    check_pop("t2_if_rdata", b1.if_rdata);
    check("t2_mem_en_idle", 32'(b1.mem_en), 32'h0);
    tick(); #1;
    check("t2_rvalid_low", 32'(b1.if_rvalid), 32'h0);
    check("t2_rdata_zero", b1.if_rdata, 32'h0);

    // Reset, then both ports held: LS, IF, LS.
    tick(); rst1 = 1'b1; #1;
    check("t3_rst_flags", flags1(), 32'h0);
    tick(); rst1 = 1'b0;
    drive1(1'b1, 32'h4, 1'b1, 1'b0, 4'h0, 32'hC, 32'h0);
    exp_q.push_back(32'h11223344);
    #1;
    check("t3_ls_gnt0", 32'(b1.ls_gnt), 32'h1);
    check("t3_if_gnt0", 32'(b1.if_gnt), 32'h0);
    check("t3_load_be", 32'(b1.mem_be), 32'hF);
    check("t3_load_addr", b1.mem_addr, 32'hC);
    tick(); exp_q.push_back(32'h00A00093); #1;
    check("t3_if_gnt1", 32'(b1.if_gnt), 32'h1);
    check("t3_ls_gnt1", 32'(b1.ls_gnt), 32'h0);
    check("t3_ls_rvalid1", 32'(b1.ls_rvalid), 32'h1);
    check_pop("t3_ls_rdata1", b1.ls_rdata);
    tick(); exp_q.push_back(32'h11223344); #1;
    check("t3_ls_gnt2", 32'(b1.ls_gnt), 32'h1);
    check("t3_if_gnt2", 32'(b1.if_gnt), 32'h0);
    check("t3_if_rvalid2", 32'(b1.if_rvalid), 32'h1);
    check_pop("t3_if_rdata2", b1.if_rdata);
    tick(); drive1(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("t3_ls_rvalid3", 32'(b1.ls_rvalid), 32'h1);
    check_pop("t3_ls_rdata3", b1.ls_rdata);
    check("t3_mem_en3", 32'(b1.mem_en), 32'h0);

    // Partial store then load of the same word.
    tick(); drive1(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h8, 32'hDEADBEEF);
    exp_q.push_back(32'h0);
    #1;
    check("t4_st_gnt", 32'(b1.ls_gnt), 32'h1);
    check("t4_st_we", 32'(b1.mem_we), 32'h1);
    check("t4_st_be", 32'(b1.mem_be), 32'h3);
    check("t4_st_addr", b1.mem_addr, 32'h8);
    check("t4_st_wdata", b1.mem_wdata, 32'hDEADBEEF);
    tick(); drive1(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    exp_q.push_back(32'h0000BEEF);
    #1;
    check("t4_st_rvalid", 32'(b1.ls_rvalid), 32'h1);
    check_pop("t4_st_rdata", b1.ls_rdata);
    check("t4_ld_gnt", 32'(b1.ls_gnt), 32'h1);
    check("t4_ld_we", 32'(b1.mem_we), 32'h0);
    check("t4_ld_be", 32'(b1.mem_be), 32'hF);
    tick(); drive1(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("t4_ld_rvalid", 32'(b1.ls_rvalid), 32'h1);
    check_pop("t4_ld_rdata", b1.ls_rdata);

    // LATENCY=3, continuous fetch; a brief LS request is dropped mid-access.
    tick(); drive3(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    exp_q.push_back(32'h12345678);
    #1;
    check("t5_gnt_t0", 32'(b3.if_gnt), 32'h1);
    check("t5_en_t0", 32'(b3.mem_en), 32'h1);
    tick(); drive3(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0); #1;
    check("t5_flags_t1", flags3(), 32'h0);
    check("t5_dbg_t1", 32'(dbg3), 32'h1);
    tick(); drive3(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("t5_flags_t2", flags3(), 32'h0);
    tick(); exp_q.push_back(32'h12345678); #1;
    check("t5_gnt_t3", 32'(b3.if_gnt), 32'h1);
    check("t5_ls_gnt_t3", 32'(b3.ls_gnt), 32'h0);
    check("t5_rvalid_t3", 32'(b3.if_rvalid), 32'h1);
    check_pop("t5_rdata_t3", b3.if_rdata);
    tick(); #1;
    check("t5_flags_t4", flags3(), 32'h0);
    tick(); #1;
    check("t5_flags_t5", flags3(), 32'h0);
    tick(); #1;
    check("t5_gnt_t6", 32'(b3.if_gnt), 32'h1);
    check("t5_rvalid_t6", 32'(b3.if_rvalid), 32'h1);
    check_pop("t5_rdata_t6", b3.if_rdata);

    // Reset one cycle after the t6 grant: its response must never appear.
    tick(); rst3 = 1'b1; drive3(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("t6_rst_flags", flags3(), 32'h0);
    tick(); rst3 = 1'b0; #1;
    check("t6_post_rst_flags", flags3(), 32'h0);
    tick(); #1;
    check("t6_no_rvalid", flags3(), 32'h0);
    check("t6_no_rdata", b3.if_rdata, 32'h0);
    tick(); drive3(1'b1, 32'h14, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    exp_q.push_back(32'hCAFEF00D);
    #1;
    check("t6_regrant", 32'(b3.if_gnt), 32'h1);
    check("t6_regrant_addr", b3.mem_addr, 32'h14);
    tick(); drive3(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check("t6_wait1", flags3(), 32'h0);
    tick(); #1;
    check("t6_wait2", flags3(), 32'h0);
    tick(); #1;
    check("t6_rvalid", 32'(b3.if_rvalid), 32'h1);
    check_pop("t6_rdata", b3.if_rdata);
    tick(); #1;
    check("t6_rvalid_low", 32'(b3.if_rvalid), 32'h0);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
